// File: rtl/dmem_arbiter_if.sv
// Signal bundle for the two-requester data-memory arbiter: requester ports,
// clear control and the shared memory port.
interface dmem_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wd;
  logic        m0_gnt;
  logic [31:0] m0_rd;
  logic        m0_rvalid;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wd;
  logic        m1_gnt;
  logic [31:0] m1_rd;
  logic        m1_rvalid;

  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;

  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wd,
    input  m1_req, m1_we, m1_addr, m1_wd,
    input  clr_start, mem_rd,
    output m0_gnt, m0_rd, m0_rvalid,
    output m1_gnt, m1_rd, m1_rvalid,
    output clr_busy, clr_done,
    output mem_we, mem_a, mem_wd
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wd,
    output m1_req, m1_we, m1_addr, m1_wd,
    output clr_start, mem_rd,
    input  m0_gnt, m0_rd, m0_rvalid,
    input  m1_gnt, m1_rd, m1_rvalid,
    input  clr_busy, clr_done,
    input  mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter granting two requesters access to one shared data memory,
// with a sequencer that sweeps the whole memory to zero on request.
module dmem_arbiter #(
  parameter int unsigned DEPTH = 64
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e          state_q;
  logic [IdxW-1:0] idx_q;
  logic            last_q;  // 1: m1 was granted most recently
  logic [31:0]     m0_rd_q, m1_rd_q;
  logic            m0_rvalid_q, m1_rvalid_q;
  logic            clr_busy_q, clr_done_q;

  logic        clearing, can_grant, gnt0, gnt1, sel_we, in_range;
  logic [31:0] sel_addr, sel_wd;

  // Reset gates every combinational output so it overrides the same cycle.
  always_comb begin
    clearing  = (state_q == StClear) && !reset;
    can_grant = (state_q == StIdle) && !bus.clr_start && !reset;
    gnt0      = can_grant && bus.m0_req && (!bus.m1_req || last_q);
    gnt1      = can_grant && bus.m1_req && (!bus.m0_req || !last_q);
    sel_we    = gnt1 ? bus.m1_we   : bus.m0_we;
    sel_addr  = gnt1 ? bus.m1_addr : bus.m0_addr;
    sel_wd    = gnt1 ? bus.m1_wd   : bus.m0_wd;
    in_range  = sel_addr[31:2] < 30'(DEPTH);

    bus.mem_we = 1'b0;
    bus.mem_a  = '0;
    bus.mem_wd = '0;
    if (clearing) begin
      bus.mem_we = 1'b1;
      bus.mem_a  = 32'({idx_q, 2'b00});
    end else if (gnt0 || gnt1) begin
      bus.mem_we = sel_we && in_range;
      bus.mem_a  = sel_addr;
      bus.mem_wd = sel_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      last_q      <= 1'b1;
      m0_rd_q     <= '0;
      m1_rd_q     <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
    end else begin
      clr_done_q  <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.clr_start) begin
            state_q    <= StClear;
            idx_q      <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        StClear: begin
          if (idx_q == IdxW'(DEPTH - 1)) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (gnt0 || gnt1) last_q <= gnt1;
      // Out-of-range reads still complete, returning zero.
      if (gnt0 && !bus.m0_we) begin
        m0_rd_q     <= in_range ? bus.mem_rd : '0;
        m0_rvalid_q <= 1'b1;
      end
      if (gnt1 && !bus.m1_we) begin
        m1_rd_q     <= in_range ? bus.mem_rd : '0;
        m1_rvalid_q <= 1'b1;
      end
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rd     = m0_rd_q;
  assign bus.m1_rd     = m1_rd_q;
  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.clr_busy  = clr_busy_q;
  assign bus.clr_done  = clr_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run against a behavioural model of arbitration and memory contents.
module tb_dmem_arbiter;
  localparam int D = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.DEPTH(D)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Physical memory driven only by the DUT's memory port.
  logic [31:0] phys [D];
  always @(posedge clk) begin
    if (bus.mem_we && bus.mem_a[31:2] < 30'(D)) phys[bus.mem_a[7:2]] <= bus.mem_wd;
  end
  assign bus.mem_rd = (bus.mem_a[31:2] < 30'(D)) ? phys[bus.mem_a[7:2]] : 32'hA5A5_5A5A;

  int total = 0;
  int bad   = 0;

  // Reference model: memory contents, who was granted last, expected read port state.
  logic [31:0] ref_mem [D];
  int          ref_last;
  logic [31:0] exp_rd [2];
  logic        exp_rv [2];

  function automatic int ref_pick(logic r0, logic r1);
    if (r0 && r1) return (ref_last == 0) ? 1 : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_grant(input int who, input logic we, input logic [31:0] a,
                             input logic [31:0] wd);
    int idx;
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
    if (who >= 0) begin
      ref_last = who;
      idx = int'(a[31:2]);
      if (we) begin
        if (idx < D) ref_mem[idx] = wd;
      end else begin
        exp_rv[who] = 1'b1;
        exp_rd[who] = (idx < D) ? ref_mem[idx] : 32'h0;
      end
    end
  endtask

  task automatic model_reset();
    ref_last  = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    exp_rv[0] = 1'b0;
    exp_rv[1] = 1'b0;
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1, input logic clr);
    bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wd = d0;
    bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wd = d1;
    bus.clr_start = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 1, 32'h8, 32'h1111, 1, 0, 32'hC, 0, 1);
    tick();
    tick();
    #4;
    total++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.clr_busy, bus.clr_done, bus.m0_rvalid,
         bus.m1_rvalid, bus.m0_rd, bus.m1_rd} !== 71'h0) begin
      bad++;
      $display("FAIL reset_state: got gnt=%b%b we=%b busy=%b done=%b rv=%b%b rd=%h/%h want 0",
               bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.clr_busy, bus.clr_done,
               bus.m0_rvalid, bus.m1_rvalid, bus.m0_rd, bus.m1_rd);
    end
    model_reset();
    tick();
    reset = 1'b0;
    drive(1, 1, 32'h0, 32'hAAAA_0001, 1, 1, 32'h4, 32'hBBBB_0002, 0);
    #4;
    total++;
    if ({bus.clr_busy, bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.mem_a, bus.mem_wd} !==
        {1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hAAAA_0001}) begin
      bad++;
      $display("FAIL first_conflict: got busy=%b gnt=%b%b we=%b a=%h wd=%h want m0 write",
               bus.clr_busy, bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.mem_a, bus.mem_wd);
    end
    model_grant(0, 1, 32'h0, 32'hAAAA_0001);
    tick();
    drive(0, 0, 0, 0, 1, 1, 32'h4, 32'hBBBB_0002, 0);
    #4;
    total++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.mem_a, bus.mem_wd} !==
        {1'b0, 1'b1, 1'b1, 32'h4, 32'hBBBB_0002}) begin
      bad++;
      $display("FAIL pending_m1: got gnt=%b%b we=%b a=%h wd=%h want m1 write",
               bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.mem_a, bus.mem_wd);
    end
    model_grant(1, 1, 32'h4, 32'hBBBB_0002);
    tick();
  endtask

  task automatic test_fill(input int n);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      drive(1, 1, 32'(i * 4), d, 0, 0, 0, 0, 0);
      #4;
      total++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.mem_a, bus.mem_wd} !==
          {1'b1, 1'b0, 1'b1, 32'(i * 4), d}) begin
        bad++;
        $display("FAIL fill_%0d: got gnt=%b%b we=%b a=%h wd=%h want 1 0 1 %h %h", i,
                 bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.mem_a, bus.mem_wd, i * 4, d);
      end
      model_grant(0, 1, 32'(i * 4), d);
      tick();
      total++;
      if (bus.m0_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL fill_rvalid_%0d: got %b want 0", i, bus.m0_rvalid);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_write_read();
    drive(1, 1, 32'h8, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    #4;
    total++;
    if ({bus.m0_gnt, bus.mem_we, bus.mem_a, bus.mem_wd} !== {1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL wr_grant: got gnt=%b we=%b a=%h wd=%h want 1 1 8 deadbeef",
               bus.m0_gnt, bus.mem_we, bus.mem_a, bus.mem_wd);
    end
    model_grant(0, 1, 32'h8, 32'hDEAD_BEEF);
    tick();
    drive(1, 0, 32'h8, 0, 0, 0, 0, 0, 0);
    #4;
    total++;
    if ({bus.m0_rvalid, bus.m0_gnt, bus.mem_we, bus.mem_a} !== {1'b0, 1'b1, 1'b0, 32'h8}) begin
      bad++;
      $display("FAIL rd_grant: got rv=%b gnt=%b we=%b a=%h want 0 1 0 8",
               bus.m0_rvalid, bus.m0_gnt, bus.mem_we, bus.mem_a);
    end
    model_grant(0, 0, 32'h8, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if ({bus.m0_rvalid, bus.m0_rd} !== {1'b1, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL rd_data: got rv=%b rd=%h want 1 deadbeef", bus.m0_rvalid, bus.m0_rd);
    end
    #4;
    total++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.mem_a, bus.mem_wd} !== 67'h0) begin
      bad++;
      $display("FAIL idle_bus: got gnt=%b%b we=%b a=%h wd=%h want 0",
               bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.mem_a, bus.mem_wd);
    end
    model_grant(-1, 0, 0, 0);
    tick();
    total++;
    if ({bus.m0_rvalid, bus.m0_rd} !== {1'b0, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL rd_hold: got rv=%b rd=%h want 0 deadbeef", bus.m0_rvalid, bus.m0_rd);
    end
  endtask

  task automatic test_conflict();
    drive(0, 0, 0, 0, 1, 0, 32'hC, 0, 0);
    #4;
    total++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL lone_m1: got gnt=%b%b want 01", bus.m0_gnt, bus.m1_gnt);
    end
    model_grant(1, 0, 32'hC, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 32'h8, 0, 1, 0, 32'hC, 0, 0);
      total++;
      if ({bus.m0_rvalid, bus.m1_rvalid, bus.m0_rd, bus.m1_rd} !==
          {exp_rv[0], exp_rv[1], exp_rd[0], exp_rd[1]}) begin
        bad++;
        $display("FAIL conflict_rv_%0d: got rv=%b%b rd=%h/%h want %b%b %h/%h", k,
                 bus.m0_rvalid, bus.m1_rvalid, bus.m0_rd, bus.m1_rd,
                 exp_rv[0], exp_rv[1], exp_rd[0], exp_rd[1]);
      end
      #4;
      total++;
      if ({bus.m0_gnt, bus.m1_gnt} !== {k % 2 == 0, k % 2 == 1}) begin
        bad++;
        $display("FAIL conflict_gnt_%0d: got %b%b want m%0d", k, bus.m0_gnt, bus.m1_gnt, k % 2);
      end
      model_grant(k % 2, 0, (k % 2 == 0) ? 32'h8 : 32'hC, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if ({bus.m1_rvalid, bus.m1_rd} !== {1'b1, exp_rd[1]}) begin
      bad++;
      $display("FAIL conflict_last_rv: got rv=%b rd=%h want 1 %h",
               bus.m1_rvalid, bus.m1_rd, exp_rd[1]);
    end
  endtask

  task automatic test_out_of_range();
    drive(1, 1, 32'h100, 32'h1234_5678, 0, 0, 0, 0, 0);
    #4;
    total++;
    if ({bus.m0_gnt, bus.mem_we, bus.mem_a} !== {1'b1, 1'b0, 32'h100}) begin
      bad++;
      $display("FAIL oor_write: got gnt=%b we=%b a=%h want 1 0 100",
               bus.m0_gnt, bus.mem_we, bus.mem_a);
    end
    model_grant(0, 1, 32'h100, 32'h1234_5678);
    tick();
    drive(1, 0, 32'h100, 0, 0, 0, 0, 0, 0);
    #4;
    model_grant(0, 0, 32'h100, 0);
    tick();
    total++;
    if ({bus.m0_rvalid, bus.m0_rd} !== {1'b1, 32'h0}) begin
      bad++;
      $display("FAIL oor_read: got rv=%b rd=%h want 1 0", bus.m0_rvalid, bus.m0_rd);
    end
    drive(1, 0, 32'h10, 0, 1, 0, 32'h14, 0, 0);
    #4;
    total++;
    if ({bus.m0_gnt, bus.m1_gnt} !== 2'b01) begin
      bad++;
      $display("FAIL oor_counts_rr: got %b%b want 01", bus.m0_gnt, bus.m1_gnt);
    end
    model_grant(1, 0, 32'h14, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if ({bus.m1_rvalid, bus.m1_rd} !== {1'b1, exp_rd[1]}) begin
      bad++;
      $display("FAIL oor_rr_read: got rv=%b rd=%h want 1 %h", bus.m1_rvalid, bus.m1_rd, exp_rd[1]);
    end
  endtask

  task automatic test_random(input int n);
    logic        p [2];
    logic        w [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic        ewe;
    logic [31:0] ea, ed;
    int          pick;
    p[0] = 1'b0;
    p[1] = 1'b0;
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!p[k] && $urandom_range(0, 3) != 0) begin
          p[k] = 1'b1;
          w[k] = 1'($urandom_range(0, 1));
          d[k] = $urandom;
          if ($urandom_range(0, 15) == 0) a[k] = $urandom;
          else a[k] = 32'($urandom_range(0, 71) * 4 + $urandom_range(0, 3));
        end
      end
      drive(p[0], w[0], a[0], d[0], p[1], w[1], a[1], d[1], 0);
      #4;
      pick = ref_pick(p[0], p[1]);
      ewe = 1'b0;
      ea  = '0;
      ed  = '0;
      if (pick >= 0) begin
        ewe = w[pick] && (a[pick][31:2] < 30'(D));
        ea  = a[pick];
        ed  = d[pick];
      end
      total++;
      if ({bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.mem_a, bus.mem_wd} !==
          {pick == 0, pick == 1, ewe, ea, ed}) begin
        bad++;
        $display("FAIL rand_bus_%0d: got gnt=%b%b we=%b a=%h wd=%h want %b%b %b %h %h", c,
                 bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.mem_a, bus.mem_wd,
                 pick == 0, pick == 1, ewe, ea, ed);
      end
      if (pick >= 0) begin
        model_grant(pick, w[pick], a[pick], d[pick]);
        p[pick] = 1'b0;
      end else begin
        model_grant(-1, 0, 0, 0);
      end
      tick();
      total++;
      if ({bus.m0_rvalid, bus.m0_rd, bus.m1_rvalid, bus.m1_rd} !==
          {exp_rv[0], exp_rd[0], exp_rv[1], exp_rd[1]}) begin
        bad++;
        $display("FAIL rand_rd_%0d: got %b %h %b %h want %b %h %b %h", c,
                 bus.m0_rvalid, bus.m0_rd, bus.m1_rvalid, bus.m1_rd,
                 exp_rv[0], exp_rd[0], exp_rv[1], exp_rd[1]);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_clear();
    drive(0, 0, 0, 0, 1, 0, 32'h10, 0, 1);
    #4;
    total++;
    if ({bus.m1_gnt, bus.m0_gnt, bus.mem_we, bus.clr_busy} !== 4'b0000) begin
      bad++;
      $display("FAIL clr_start_cycle: got gnt1=%b gnt0=%b we=%b busy=%b want 0",
               bus.m1_gnt, bus.m0_gnt, bus.mem_we, bus.clr_busy);
    end
    model_grant(-1, 0, 0, 0);
    tick();
    for (int i = 0; i < D; i++) begin
      drive(0, 0, 0, 0, 1, 0, 32'h10, 0, (i < 5) ? 1'b1 : 1'b0);
      #4;
      total++;
      if ({bus.clr_busy, bus.clr_done, bus.m0_gnt, bus.m1_gnt, bus.mem_we, bus.mem_a,
           bus.mem_wd} !== {5'b10001, 32'(i * 4), 32'h0}) begin
        bad++;
        $display("FAIL clear_%0d: got busy=%b done=%b gnt=%b%b we=%b a=%h wd=%h want 1 0 00 1 %h 0",
                 i, bus.clr_busy, bus.clr_done, bus.m0_gnt, bus.m1_gnt, bus.mem_we,
                 bus.mem_a, bus.mem_wd, i * 4);
      end
      ref_mem[i] = '0;
      model_grant(-1, 0, 0, 0);
      tick();
    end
    #4;
    total++;
    if ({bus.clr_busy, bus.clr_done, bus.m1_gnt, bus.m0_gnt} !== 4'b0110) begin
      bad++;
      $display("FAIL clear_end: got busy=%b done=%b gnt1=%b gnt0=%b want 0 1 1 0",
               bus.clr_busy, bus.clr_done, bus.m1_gnt, bus.m0_gnt);
    end
    model_grant(1, 0, 32'h10, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    total++;
    if ({bus.clr_done, bus.m1_rvalid, bus.m1_rd} !== {2'b01, 32'h0}) begin
      bad++;
      $display("FAIL clear_after: got done=%b rv=%b rd=%h want 0 1 0",
               bus.clr_done, bus.m1_rvalid, bus.m1_rd);
    end
  endtask

  task automatic read_words(input int lo, input int hi);
    for (int w = lo; w <= hi; w++) begin
      drive(1, 0, 32'(w * 4), 0, 0, 0, 0, 0, 0);
      #4;
      total++;
      if (bus.m0_gnt !== 1'b1) begin
        bad++;
        $display("FAIL readback_gnt_%0d: got %b want 1", w, bus.m0_gnt);
      end
      model_grant(0, 0, 32'(w * 4), 0);
      tick();
      total++;
      if ({bus.m0_rvalid, bus.m0_rd} !== {1'b1, exp_rd[0]}) begin
        bad++;
        $display("FAIL readback_%0d: got rv=%b rd=%h want 1 %h", w, bus.m0_rvalid, bus.m0_rd,
                 exp_rd[0]);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_abort();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #4;
    model_grant(-1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      #4;
      total++;
      if ({bus.clr_busy, bus.mem_we, bus.mem_a} !== {2'b11, 32'(i * 4)}) begin
        bad++;
        $display("FAIL abort_sweep_%0d: got busy=%b we=%b a=%h want 1 1 %h", i,
                 bus.clr_busy, bus.mem_we, bus.mem_a, i * 4);
      end
      ref_mem[i] = '0;
      tick();
    end
    reset = 1'b1;
    #4;
    total++;
    if (bus.mem_we !== 1'b0) begin
      bad++;
      $display("FAIL abort_we: got %b want 0", bus.mem_we);
    end
    tick();
    reset = 1'b0;
    model_reset();
    #4;
    total++;
    if ({bus.clr_busy, bus.clr_done, bus.m0_rvalid, bus.m0_rd} !== 35'h0) begin
      bad++;
      $display("FAIL abort_state: got busy=%b done=%b rv=%b rd=%h want 0",
               bus.clr_busy, bus.clr_done, bus.m0_rvalid, bus.m0_rd);
    end
    tick();
    total++;
    if ({bus.clr_busy, bus.clr_done} !== 2'b00) begin
      bad++;
      $display("FAIL abort_no_done: got busy=%b done=%b want 0 0", bus.clr_busy, bus.clr_done);
    end
    read_words(0, 10);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_fill(D);
    test_write_read();
    test_conflict();
    test_out_of_range();
    test_random(400);
    test_clear();
    test_fill(16);
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
